// File: rtl/z_writeback.sv
// Z-register writeback: captures the ALU result and its opcode, then drains it onto
// the 32-bit internal bus as one gp beat or as an LO/HI beat pair for mul/div.
module z_writeback #(
  parameter int          DATA_W   = 32,
  parameter logic [4:0]  OP_MUL   = 5'b00011,
  parameter logic [4:0]  OP_DIV   = 5'b00100,
  parameter int          MAX_WAIT = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [2*DATA_W-1:0]   alu_c,
  input  logic [4:0]            alu_op,
  input  logic                  z_in,
  input  logic                  bus_ready,
  output logic [DATA_W-1:0]     bus_out,
  output logic                  bus_valid,
  output logic                  lo_en,
  output logic                  hi_en,
  output logic                  gp_en,
  output logic                  busy,
  output logic                  done,
  output logic                  ovr,
  output logic                  tmo
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT_LO,
    S_BEAT_HI,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [2*DATA_W-1:0]  z_q, z_d;
  logic [4:0]           op_q, op_d;
  logic [CNT_W-1:0]     wait_q, wait_d;
  logic                 ovr_q, ovr_d;
  logic                 tmo_q, tmo_d;
  logic                 wide;

  assign wide = (op_q == OP_MUL) || (op_q == OP_DIV);

  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    op_d    = op_q;
    wait_d  = wait_q;
    ovr_d   = ovr_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (z_in) begin
          z_d     = alu_c;
          op_d    = alu_op;
          wait_d  = '0;
          state_d = S_BEAT_LO;
        end
      end
      S_BEAT_LO, S_BEAT_HI: begin
        if (z_in) ovr_d = 1'b1;
        if (bus_ready) begin
          wait_d  = '0;
          state_d = (state_q == S_BEAT_LO && wide) ? S_BEAT_HI : S_DONE;
        end else if (wait_q == CNT_W'(MAX_WAIT - 1)) begin
          // This stall cycle would bring the count to MAX_WAIT: abandon the transfer.
          wait_d  = '0;
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (z_in) ovr_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      z_q     <= '0;
      op_q    <= '0;
      wait_q  <= '0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
    end
  end

  // Outputs decode from registered state only, so they hold steady under backpressure.
  always_comb begin
    bus_out   = '0;
    bus_valid = 1'b0;
    lo_en     = 1'b0;
    hi_en     = 1'b0;
    gp_en     = 1'b0;
    case (state_q)
      S_BEAT_LO: begin
        bus_out   = z_q[DATA_W-1:0];
        bus_valid = 1'b1;
        lo_en     = wide;
        gp_en     = !wide;
      end
      S_BEAT_HI: begin
        bus_out   = z_q[2*DATA_W-1:DATA_W];
        bus_valid = 1'b1;
        hi_en     = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign ovr  = ovr_q;
  assign tmo  = tmo_q;

endmodule

// File: tb/tb_z_writeback.sv
// Directed bench for z_writeback: single/dual beats, backpressure, watchdog, overrun, reset.
module tb_z_writeback;

  logic        clk = 1'b0;
  logic        clr;
  logic [63:0] alu_c;
  logic [4:0]  alu_op;
  logic        z_in;
  logic        bus_ready;
  logic [31:0] bus_out;
  logic        bus_valid, lo_en, hi_en, gp_en, busy, done, ovr, tmo;

  int checks   = 0;
  int failures = 0;

  z_writeback dut (
    .clk(clk), .clr(clr), .alu_c(alu_c), .alu_op(alu_op), .z_in(z_in),
    .bus_ready(bus_ready), .bus_out(bus_out), .bus_valid(bus_valid),
    .lo_en(lo_en), .hi_en(hi_en), .gp_en(gp_en), .busy(busy), .done(done),
    .ovr(ovr), .tmo(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [4:0] op, input logic [63:0] c);
    alu_op = op;
    alu_c  = c;
    z_in   = 1'b1;
    tick();
    z_in   = 1'b0;
  endtask

  initial begin
    clr = 1'b1; alu_c = '0; alu_op = '0; z_in = 1'b0; bus_ready = 1'b0;
    tick();
    tick();
    clr = 1'b0;
    chk("rst_bus_out", bus_out, 0);
    chk("rst_valid", bus_valid, 0);
    chk("rst_enables", {lo_en, hi_en, gp_en}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_ovr_tmo", {ovr, tmo}, 0);

    // Add, single gp beat
    bus_ready = 1'b1;
    capture(5'b00001, 64'h0000_0000_0000_0007);
    chk("add_data", bus_out, 32'h7);
    chk("add_en", {bus_valid, lo_en, hi_en, gp_en}, 4'b1001);
    tick();
    chk("add_done", {done, bus_valid, lo_en, hi_en}, 4'b1000);
    tick();
    chk("add_idle", {done, busy}, 2'b00);

    // Mul, two beats back to back
    capture(5'b00011, 64'h0000_0001_8000_0000);
    chk("mul_lo_data", bus_out, 32'h8000_0000);
    chk("mul_lo_en", {bus_valid, lo_en, hi_en, gp_en}, 4'b1100);
    tick();
    chk("mul_hi_data", bus_out, 32'h0000_0001);
    chk("mul_hi_en", {bus_valid, lo_en, hi_en, gp_en}, 4'b1010);
    tick();
    chk("mul_done", {done, bus_valid}, 2'b10);
    tick();

    // Undefined opcode: single gp beat of the low word only
    capture(5'b11111, 64'hDEAD_BEEF_1234_5678);
    chk("undef_data", bus_out, 32'h1234_5678);
    chk("undef_en", {bus_valid, lo_en, hi_en, gp_en}, 4'b1001);
    tick();
    chk("undef_done", {done, bus_valid, hi_en}, 3'b100);
    tick();

    // Div with 3 cycles of backpressure
    bus_ready = 1'b0;
    capture(5'b00100, 64'h0000_0003_0000_0005);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_lo_hold%0d", i), {bus_valid, lo_en, hi_en, gp_en, bus_out}, {4'b1100, 32'h5});
      tick();
    end
    bus_ready = 1'b1;
    chk("bp_lo_xfer", {bus_valid, lo_en, hi_en, gp_en, bus_out}, {4'b1100, 32'h5});
    tick();
    chk("bp_hi", {bus_valid, lo_en, hi_en, gp_en, bus_out}, {4'b1010, 32'h3});
    tick();
    chk("bp_done_tmo", {done, tmo}, 2'b10);
    tick();

    // Transfer on the last allowed cycle is accepted
    bus_ready = 1'b0;
    capture(5'b00001, 64'h11);
    for (int i = 0; i < 15; i++) tick();
    bus_ready = 1'b1;
    chk("edge_valid", {bus_valid, gp_en, bus_out}, {2'b11, 32'h11});
    tick();
    chk("edge_done", {done, tmo}, 2'b10);
    tick();

    // Timeout: 16 stalled cycles then abort
    bus_ready = 1'b0;
    capture(5'b00001, 64'h9);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("tmo_valid%0d", i), bus_valid, 1);
      tick();
    end
    chk("tmo_drop", {bus_valid, busy, done, tmo}, 4'b0001);
    chk("tmo_enables", {lo_en, hi_en, gp_en}, 0);
    tick();
    chk("tmo_no_done", {done, busy}, 0);
    bus_ready = 1'b1;
    capture(5'b00001, 64'h42);
    chk("tmo_recap", {bus_valid, gp_en, bus_out}, {2'b11, 32'h42});
    tick();
    chk("tmo_recap_done", {done, tmo}, 2'b11);
    tick();

    // Overrun while BEAT_LO is stalled
    bus_ready = 1'b0;
    capture(5'b00001, 64'h1);
    capture(5'b00001, 64'h2);
    chk("ovr_flag", ovr, 1);
    chk("ovr_data", {bus_valid, gp_en, bus_out}, {2'b11, 32'h1});
    bus_ready = 1'b1;
    tick();
    chk("ovr_done", {done, ovr}, 2'b11);
    tick();

    // Reset during BEAT_HI
    capture(5'b00011, 64'hAAAA_BBBB_CCCC_DDDD);
    tick();
    chk("rmid_hi", {hi_en, bus_out}, {1'b1, 32'hAAAA_BBBB});
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("rmid_outs", {bus_valid, lo_en, hi_en, gp_en, busy, done, ovr, tmo, bus_out}, 0);
    tick();
    chk("rmid_no_done", {done, busy, bus_valid}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/z_writeback.md
Name: z_writeback

Overview:
- Result-side consumer of the ALU's registered 64-bit output C.
- Captures C together with the opcode that produced it into an internal Z register.
- Drives the captured result onto the 32-bit internal bus through a valid/ready handshake:
  - mul/div results go out in two beats, low word to LO and high word to HI.
  - All other opcodes go out in one beat to the general-purpose destination.
- Includes a stall watchdog and a sticky overrun/timeout status for the control unit.

Parameters:
- DATA_W, 32, bus word width; the Z register is 2*DATA_W.
- OP_MUL, 5'b00011, opcode producing a 64-bit product (HI = C[63:32], LO = C[31:0]).
- OP_DIV, 5'b00100, opcode producing remainder/quotient (HI = remainder = C[63:32], LO = quotient = C[31:0]).
- MAX_WAIT, 16, cycles a beat may wait for bus_ready before abort; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous, active-high reset.
- alu_c  in  64  ALU result C.
- alu_op  in  5  opcode that produced alu_c.
- z_in  in  1  capture strobe; alu_c/alu_op are valid in the same cycle.
- bus_ready  in  1  bus accepts the current beat.
- bus_out  out  32  beat data.
- bus_valid  out  1  beat present on bus_out.
- lo_en  out  1  current beat targets LO; qualified by bus_valid.
- hi_en  out  1  current beat targets HI; qualified by bus_valid.
- gp_en  out  1  current beat targets the general-purpose destination; qualified by bus_valid.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the final beat completes.
- ovr  out  1  sticky: z_in was asserted while busy.
- tmo  out  1  sticky: a beat exceeded MAX_WAIT.

Behaviour:
- Reset: clr high at a clock edge forces state IDLE, Z register = 0, wait counter = 0, and all outputs = 0 (including bus_out, ovr, tmo). Reset mid-transfer aborts the transfer with no done pulse.
- States are IDLE, BEAT_LO, BEAT_HI, DONE.
- IDLE:
  - On z_in at edge N: Z <= alu_c, op_q <= alu_op, go to BEAT_LO.
  - bus_valid is high from cycle N+1, giving 1-cycle capture latency.
- BEAT_LO:
  - bus_out = Z[31:0], bus_valid = 1.
  - lo_en = 1 if op_q is OP_MUL or OP_DIV; otherwise gp_en = 1.
  - Transfer occurs on a cycle with bus_valid & bus_ready.
  - After transfer: go to BEAT_HI if op_q is mul/div, else go to DONE.
- BEAT_HI: bus_out = Z[63:32], bus_valid = 1, hi_en = 1. After transfer, go to DONE.
- DONE: done = 1 for exactly one cycle, then return to IDLE.
  - z_in is not accepted in DONE; a new capture is possible the cycle after done.
- Handshake rules:
  - bus_out and the enables stay stable while bus_valid is high and bus_ready is low.
  - bus_ready high in IDLE or DONE is ignored.
  - bus_ready may be held high continuously, giving one beat per cycle.
- Enable exclusivity: at most one of lo_en/hi_en/gp_en is high; all are 0 when bus_valid = 0.
- Opcode handling: any opcode other than OP_MUL or OP_DIV, including 0 and undefined values, is a single gp beat of Z[31:0]. The Z[63:32] content is not emitted.
- Watchdog:
  - The wait counter clears on entry to each beat and increments each cycle of that beat without transfer.
  - If the counter reaches MAX_WAIT with bus_ready still low: set tmo, drop bus_valid, go to IDLE, no done pulse.
  - A transfer in the same cycle the count reaches MAX_WAIT is accepted normally.
- Overrun: z_in in any non-IDLE state is ignored and sets ovr. Z and op_q are not disturbed.
- Status clear: ovr and tmo clear only on clr.
- Simultaneous clr with z_in or bus_ready: clr wins.

Test Plan:
- Add, single beat: alu_op=00001, alu_c=64'h0000_0000_0000_0007, z_in for 1 cycle, bus_ready held 1 -> next cycle bus_out=7 with gp_en=1; the following cycle done=1; lo_en/hi_en never high.
- Mul, two beats: alu_op=00011, alu_c=64'h0000_0001_8000_0000, bus_ready held 1 -> beats 32'h8000_0000 (lo_en), then 32'h0000_0001 (hi_en) on consecutive cycles, then a done pulse.
- Backpressure: div with alu_c=64'h0000_0003_0000_0005, bus_ready low 3 cycles then high -> bus_out=5 with lo_en held stable for 4 cycles; then 3 with hi_en; tmo stays 0.
- Timeout (MAX_WAIT=16): bus_ready held 0 after capture -> bus_valid drops after 16 cycles, tmo=1, busy=0, no done; a subsequent capture works normally while tmo stays 1.
- Overrun: z_in with alu_c=1 (add), then z_in with alu_c=2 while BEAT_LO is stalled -> ovr=1 and the emitted beat is still 1.
- Reset mid-mul: clr asserted during BEAT_HI -> next cycle all outputs 0, state IDLE, no done pulse; ovr/tmo cleared.
